// File: rtl/stream_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// stream_delay_line_pkg
// Shared helpers for the stream delay line:
//   delay_width(max_depth)  width needed to hold a depth/count of 0..max_depth
//   sat_delay(req, max)     clamps a requested depth to the physical stage count
// -----------------------------------------------------------------------------
package stream_delay_line_pkg;

  // Width of the depth and occupancy fields; both range over 0..max_depth.
  function automatic int delay_width(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // Requests beyond the number of physical stages are clamped to the maximum.
  function automatic int sat_delay(input int req, input int max_depth);
    return (req > max_depth) ? max_depth : req;
  endfunction

endpackage

// File: rtl/stream_delay_stage.sv
// -----------------------------------------------------------------------------
// stream_delay_stage
// One slot of the delay line: a payload register plus its valid bit.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears valid and payload)
//   clear_i  drop the held beat (valid only; payload is kept)
//   load_i   stage accepts this cycle: take valid/data from the source
//   valid_i  source valid (previous stage or the stream input)
//   data_i   source payload
//   valid_o  held valid
//   data_o   held payload
// -----------------------------------------------------------------------------
module stream_delay_stage #(
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic valid_i,
  input  dtype data_i,
  output logic valid_o,
  output dtype data_o
);

  logic valid_q, valid_d;
  dtype data_q, data_d;

  // A load copies the source slot, including an empty one; that is how
  // bubbles move forward and get squeezed out behind a stalled head.
  // Clear wins over load so a flush or deactivation always empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_delay_line.sv
// -----------------------------------------------------------------------------
// stream_delay_line
// Stallable valid/ready delay line with a runtime depth D in 0..MaxDepth.
// D = 0 is a combinational pass-through; otherwise the output is stage D-1
// and a combinational ready chain lets bubbles collapse under backpressure.
//
// Parameters: dtype (payload type), MaxDepth (physical stages, >= 1),
//             DefaultDepth (depth after reset, <= MaxDepth).
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            drop every beat in flight, stall both sides this cycle
//   delay_i / delay_o  requested depth / depth currently applied
//   valid_i, ready_o, data_i   upstream handshake
//   valid_o, ready_i, data_o   downstream handshake
//   empty_o, count_o           occupancy (registered state)
//
// Build option: define STREAM_DELAY_LINE_COUNT_EN to add an up/down beat
// counter driving count_o and empty_o. Without it count_o is zero and
// empty_o is derived from the stage valid bits.
// -----------------------------------------------------------------------------
module stream_delay_line
  import stream_delay_line_pkg::*;
#(
  parameter type dtype        = logic,
  parameter int  MaxDepth     = 4,
  parameter int  DefaultDepth = 2,
  localparam int DelayWidth   = delay_width(MaxDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DelayWidth-1:0] delay_i,
  output logic [DelayWidth-1:0] delay_o,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  dtype                  data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output dtype                  data_o,
  output logic                  empty_o,
  output logic [DelayWidth-1:0] count_o
);

  logic [DelayWidth-1:0] depth_q, depth_d;
  logic [MaxDepth-1:0]   valid_q;
  logic [MaxDepth-1:0]   active;
  logic [MaxDepth-1:0]   accept;
  dtype                  data_q [MaxDepth];
  logic                  sel_valid;
  dtype                  sel_data;
  logic                  in_xfer;

  // Stages at or beyond the current depth are held empty.
  always_comb begin
    for (int k = 0; k < MaxDepth; k++) begin
      active[k] = (k < int'(depth_q));
    end
  end

  // Ready chain, walked from the output back toward the input: a stage can
  // take a beat if it is empty or everything ahead of it moves. Inactive
  // stages leave the chain at ready_i, so with D = 0 accept[0] is ready_i.
  always_comb begin : p_accept
    logic chain;
    chain = ready_i;
    for (int k = MaxDepth - 1; k >= 0; k--) begin
      if (active[k]) begin
        chain = ~valid_q[k] | chain;
      end
      accept[k] = chain;
    end
  end

  for (genvar k = 0; k < MaxDepth; k++) begin : g_stage
    logic src_valid;
    dtype src_data;

    if (k == 0) begin : g_head
      assign src_valid = valid_i;
      assign src_data  = data_i;
    end else begin : g_body
      assign src_valid = valid_q[k-1];
      assign src_data  = data_q[k-1];
    end

    stream_delay_stage #(
      .dtype (dtype)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i | ~active[k]),
      .load_i  (accept[k]),
      .valid_i (src_valid),
      .data_i  (src_data),
      .valid_o (valid_q[k]),
      .data_o  (data_q[k])
    );
  end

  // Output select: the input itself when D = 0, otherwise stage D-1.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    if (depth_q == '0) begin
      sel_valid = valid_i;
      sel_data  = data_i;
    end else begin
      for (int k = 0; k < MaxDepth; k++) begin
        if (int'(depth_q) == k + 1) begin
          sel_valid = valid_q[k];
          sel_data  = data_q[k];
        end
      end
    end
  end

  // Flush stalls both handshakes so nothing is accepted or emitted while
  // the stages are being emptied.
  assign ready_o = ~flush_i & accept[0];
  assign valid_o = ~flush_i & sel_valid;
  assign data_o  = sel_data;
  assign delay_o = depth_q;
  assign in_xfer = valid_i & ready_o;

`ifdef STREAM_DELAY_LINE_COUNT_EN
  logic                  out_xfer;
  logic [DelayWidth-1:0] count_q, count_d;

  assign out_xfer = valid_o & ready_i;

  // Simultaneous in and out transfers leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (in_xfer && !out_xfer) begin
      count_d = count_q + DelayWidth'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - DelayWidth'(1);
    end
    if (flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
`else
  assign count_o = '0;
  assign empty_o = ~|valid_q;
`endif

  // The depth only changes while nothing is in flight and no beat enters,
  // so a beat never sees two different depths.
  always_comb begin
    depth_d = depth_q;
    if (empty_o && !in_xfer) begin
      depth_d = DelayWidth'(sat_delay(int'(delay_i), MaxDepth));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_q <= DelayWidth'(DefaultDepth);
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: tb/tb_stream_delay_line.sv
// -----------------------------------------------------------------------------
// tb_stream_delay_line
// Self-checking bench for stream_delay_line (dtype = logic [7:0], MaxDepth = 4,
// DefaultDepth = 2). A beat-queue model predicts the outputs every cycle;
// directed sequences add hand-computed literal expectations.
// Honours STREAM_DELAY_LINE_COUNT_EN for the expected count_o.
// -----------------------------------------------------------------------------
module tb_stream_delay_line;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [2:0] delay_i;
  logic [2:0] delay_o;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic [2:0] count_o;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: beats in flight, oldest first, each with its slot position
  // (0 = just entered, D-1 = presented at the output).
  logic [7:0] mData[$];
  int         mPos[$];
  int         mDepth = 2;

  logic [23:0] validPat = 24'b1101_1111_0110_1011_1110_0111;
  logic [23:0] readyPat = 24'b0011_1010_1111_0001_0110_1101;

  stream_delay_line #(
    .dtype        (logic [7:0]),
    .MaxDepth     (4),
    .DefaultDepth (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .delay_i (delay_i),
    .delay_o (delay_o),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .empty_o (empty_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected occupancy report for n beats in flight.
  function automatic logic [7:0] litCount(input int n);
`ifdef STREAM_DELAY_LINE_COUNT_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  // Outputs implied by the beat queue: the oldest beat is visible once it
  // has reached the last slot; the line takes a beat unless all D slots are
  // full and downstream stalls.
  function automatic void modelOutputs(output logic expValid, output logic expReady,
                                       output logic [7:0] expData);
    expData  = 8'h00;
    expValid = 1'b0;
    if (mDepth == 0) begin
      expValid = valid_i & ~flush_i;
      expReady = ready_i & ~flush_i;
      expData  = data_i;
    end else begin
      expReady = ~flush_i & ((mPos.size() < mDepth) | ready_i);
      if (mPos.size() > 0) begin
        expValid = ~flush_i & (mPos[0] == mDepth - 1);
        expData  = mData[0];
      end
    end
  endfunction

  // Advance the model at each active edge using the pre-edge inputs.
  always @(posedge clk) begin : p_model
    logic       ev, er, inXfer, wasEmpty;
    logic [7:0] ed;
    int         lim, np;
    if (rst_i) begin
      mPos.delete();
      mData.delete();
      mDepth = 2;
    end else begin
      modelOutputs(ev, er, ed);
      inXfer   = valid_i & er;
      wasEmpty = (mPos.size() == 0);
      if (flush_i) begin
        mPos.delete();
        mData.delete();
      end else if (mDepth > 0) begin
        // Each beat moves one slot forward unless the beat ahead blocks it.
        lim = ready_i ? mDepth : mDepth - 1;
        for (int i = 0; i < mPos.size(); i++) begin
          np      = (mPos[i] + 1 < lim) ? mPos[i] + 1 : lim;
          mPos[i] = np;
          lim     = np - 1;
        end
        if (mPos.size() > 0 && mPos[0] == mDepth) begin
          void'(mPos.pop_front());
          void'(mData.pop_front());
        end
        if (inXfer) begin
          mPos.push_back(0);
          mData.push_back(data_i);
        end
      end
      if (wasEmpty && !inXfer) begin
        mDepth = (delay_i > 3'd4) ? 4 : int'(delay_i);
      end
    end
  end

  // Compare the DUT against the model on every cycle out of reset.
  always @(negedge clk) begin : p_compare
    logic       ev, er;
    logic [7:0] ed;
    if (!rst_i) begin
      modelOutputs(ev, er, ed);
      checkOutput("model valid_o", 8'(valid_o), 8'(ev));
      checkOutput("model ready_o", 8'(ready_o), 8'(er));
      if (ev) begin
        checkOutput("model data_o", data_o, ed);
      end
      checkOutput("model delay_o", 8'(delay_o), 8'(mDepth));
      checkOutput("model empty_o", 8'(empty_o), (mPos.size() == 0) ? 8'd1 : 8'd0);
      checkOutput("model count_o", 8'(count_o), litCount(mPos.size()));
    end
  end

  // Drive one cycle of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                               input logic fl, input logic [2:0] dly);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = fl;
    delay_i = dly;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : p_main
    rst_i   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = 8'h00;
    delay_i = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    $display("[TB] reset state");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
    checkOutput("reset delay_o", 8'(delay_o), 8'd2);
    checkOutput("reset valid_o", 8'(valid_o), 8'd0);
    checkOutput("reset ready_o", 8'(ready_o), 8'd1);
    checkOutput("reset empty_o", 8'(empty_o), 8'd1);
    checkOutput("reset count_o", 8'(count_o), 8'd0);
    checkOutput("reset data_o", data_o, 8'h00);
    nextCycle();

    $display("[TB] latency and ordering, D=2");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 8, 8'(8'h10 + i), 1'b1, 1'b0, 3'd2);
      checkOutput("stream ready_o", 8'(ready_o), 8'd1);
      checkOutput("stream valid_o", 8'(valid_o), (i >= 2 && i <= 9) ? 8'd1 : 8'd0);
      if (i >= 2 && i <= 9) begin
        checkOutput("stream data_o", data_o, 8'(8'h10 + i - 2));
      end
      nextCycle();
    end

    $display("[TB] backpressure, D=4");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd4);
    nextCycle();
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 8'(8'h20 + j), 1'b0, 1'b0, 3'd4);
      checkOutput("bp delay_o", 8'(delay_o), 8'd4);
      checkOutput("bp fill ready_o", 8'(ready_o), 8'd1);
      nextCycle();
    end
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b1, 8'h24, 1'b0, 1'b0, 3'd4);
      checkOutput("bp full ready_o", 8'(ready_o), 8'd0);
      checkOutput("bp full valid_o", 8'(valid_o), 8'd1);
      checkOutput("bp full data_o", data_o, 8'h20);
      checkOutput("bp full count_o", 8'(count_o), litCount(4));
      checkOutput("bp full empty_o", 8'(empty_o), 8'd0);
      nextCycle();
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd4);
      checkOutput("bp drain valid_o", 8'(valid_o), (k < 4) ? 8'd1 : 8'd0);
      if (k < 4) begin
        checkOutput("bp drain data_o", data_o, 8'(8'h20 + k));
      end else begin
        checkOutput("bp drain empty_o", 8'(empty_o), 8'd1);
      end
      nextCycle();
    end

    $display("[TB] depth change");
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 3'd3);
    checkOutput("depth busy delay_o", 8'(delay_o), 8'd4);
    nextCycle();
    for (int t = 1; t < 6; t++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
      checkOutput("depth hold delay_o", 8'(delay_o), 8'd4);
      checkOutput("depth valid_o", 8'(valid_o), (t == 4) ? 8'd1 : 8'd0);
      if (t == 4) begin
        checkOutput("depth data_o", data_o, 8'h30);
      end
      if (t == 5) begin
        checkOutput("depth drained empty_o", 8'(empty_o), 8'd1);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd7);
    checkOutput("depth applied delay_o", 8'(delay_o), 8'd3);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
    checkOutput("depth saturated delay_o", 8'(delay_o), 8'd4);
    nextCycle();

    $display("[TB] pass-through, D=0");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA5, (i % 2) == 1, 1'b0, 3'd0);
      checkOutput("pass delay_o", 8'(delay_o), 8'd0);
      checkOutput("pass valid_o", 8'(valid_o), 8'd1);
      checkOutput("pass data_o", data_o, 8'hA5);
      checkOutput("pass ready_o", 8'(ready_o), ((i % 2) == 1) ? 8'd1 : 8'd0);
      checkOutput("pass empty_o", 8'(empty_o), 8'd1);
      checkOutput("pass count_o", 8'(count_o), 8'd0);
      nextCycle();
    end

    $display("[TB] flush, D=3");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
    nextCycle();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 8'(8'h50 + j), 1'b0, 1'b0, 3'd3);
      nextCycle();
    end
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 3'd3);
    checkOutput("flush valid_o", 8'(valid_o), 8'd0);
    checkOutput("flush ready_o", 8'(ready_o), 8'd0);
    checkOutput("flush count_o", 8'(count_o), litCount(3));
    checkOutput("flush empty_o", 8'(empty_o), 8'd0);
    nextCycle();
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b0, 3'd3);
    checkOutput("post flush empty_o", 8'(empty_o), 8'd1);
    checkOutput("post flush count_o", 8'(count_o), 8'd0);
    checkOutput("post flush ready_o", 8'(ready_o), 8'd1);
    checkOutput("post flush valid_o", 8'(valid_o), 8'd0);
    checkOutput("post flush delay_o", 8'(delay_o), 8'd3);
    nextCycle();
    for (int t = 1; t < 4; t++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd3);
      checkOutput("refill valid_o", 8'(valid_o), (t == 3) ? 8'd1 : 8'd0);
      if (t == 3) begin
        checkOutput("refill data_o", data_o, 8'h42);
      end
      nextCycle();
    end

    $display("[TB] mixed valid/ready pattern, D=3 then D=1");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(validPat[i], 8'(8'h60 + i), readyPat[i], 1'b0, 3'd3);
      nextCycle();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd1);
      nextCycle();
    end
    for (int i = 0; i < 24; i++) begin
      applyStimulus(validPat[23 - i], 8'(8'h80 + i), readyPat[i], 1'b0, 3'd1);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
      nextCycle();
    end

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 3'd2);
      nextCycle();
    end
    rst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
    nextCycle();
    rst_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
    checkOutput("mid reset valid_o", 8'(valid_o), 8'd0);
    checkOutput("mid reset empty_o", 8'(empty_o), 8'd1);
    checkOutput("mid reset count_o", 8'(count_o), 8'd0);
    checkOutput("mid reset delay_o", 8'(delay_o), 8'd2);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
